data_mem_responder: RTL and testbench

//  Data-memory responder: the target end of the control unit's memory strobes.
//  - Accepts read/write requests on address addsel; returns data, a one-cycle ready pulse and an error flag.
//  - Also feeds the low address bits of returned data back as dataout_mem for indirect (mode 2) addressing.
//  - Sits between controlunit and the register file / datapath buses.

---
 rtl/data_mem_responder.sv | 132 +++++++++++++
 tb/tb_data_mem_responder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Purpose  : Data-memory target for the control unit's read/write strobes.
//            Serialised accesses with optional wait states, a one-cycle
//            ready/err pulse and an indirect-address return path.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int DEPTH       = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addsel,
  input  logic [DATA_W-1:0] datain,
  output logic [DATA_W-1:0] dataout,
  output logic [ADDR_W-1:0] dataout_mem,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_wait = 2'd1;
  localparam logic [1:0] c_st_resp = 2'd2;

  // Memory index width; DEPTH is expected not to exceed 2**ADDR_W.
  localparam int              c_idx_w     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] c_depth     = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]      c_wait_init = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam bit              c_no_wait   = (WAIT_STATES == 0);

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic [3:0]        r_cnt;
  logic              r_op_wr;
  logic              r_oor;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_dataout;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_req;
  logic              w_oor;
  logic              w_enter_resp;
  logic              w_acc_wr;
  logic              w_acc_oor;
  logic [ADDR_W-1:0] w_acc_addr;
  logic [DATA_W-1:0] w_acc_data;
  logic [c_idx_w-1:0] w_acc_idx;

  assign w_req = read | write;
  assign w_oor = ({1'b0, addsel} >= c_depth);

  // Access happens on the edge entering RESP: straight from IDLE when there
  // are no wait states, otherwise when the WAIT counter has run out.
  assign w_enter_resp = ((r_state == c_st_idle) && w_req && c_no_wait) ||
                        ((r_state == c_st_wait) && (r_cnt == 4'd0));

  // From IDLE the request is used live (it is being latched on the same edge);
  // from WAIT the latched copy is used. Read+write together behaves as write.
  assign w_acc_wr   = (r_state == c_st_idle) ? write  : r_op_wr;
  assign w_acc_oor  = (r_state == c_st_idle) ? w_oor  : r_oor;
  assign w_acc_addr = (r_state == c_st_idle) ? addsel : r_addr;
  assign w_acc_data = (r_state == c_st_idle) ? datain : r_data;
  assign w_acc_idx  = w_acc_addr[c_idx_w-1:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_st_idle;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle: if (w_req) w_next_state = c_no_wait ? c_st_resp : c_st_wait;
      c_st_wait: if (r_cnt == 4'd0) w_next_state = c_st_resp;
      c_st_resp: w_next_state = c_st_idle;
      default:   w_next_state = c_st_idle;
    endcase
  end

  // Outputs decoded from state; err reflects the request latched in IDLE
  always_comb begin
    ready = (r_state == c_st_resp);
    busy  = (r_state != c_st_idle);
    err   = (r_state == c_st_resp) && r_err;
  end

  // Request capture, wait counter, memory array and read-data register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= 4'd0;
      r_op_wr   <= 1'b0;
      r_oor     <= 1'b0;
      r_err     <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_dataout <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if ((r_state == c_st_idle) && w_req) begin
        r_op_wr <= write;
        r_oor   <= w_oor;
        r_err   <= w_oor | (read & write);
        r_addr  <= addsel;
        r_data  <= datain;
        r_cnt   <= c_wait_init;
      end else if ((r_state == c_st_wait) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // Out-of-range accesses neither write memory nor touch dataout
      if (w_enter_resp && !w_acc_oor) begin
        if (w_acc_wr) r_mem[w_acc_idx] <= w_acc_data;
        else          r_dataout        <= r_mem[w_acc_idx];
      end
    end
  end

  assign dataout     = r_dataout;
  assign dataout_mem = r_dataout[ADDR_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Purpose  : Self-checking bench for data_mem_responder. Three instances with
//            different WAIT_STATES / DEPTH share clock and reset; a table of
//            transactions is applied and results checked via a scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        rd   [3];
  logic        wr   [3];
  logic [4:0]  addr [3];
  logic [31:0] din  [3];
  logic [31:0] dout [3];
  logic [4:0]  dmem [3];
  logic        rdy  [3];
  logic        bsy  [3];
  logic        er   [3];

  int n_checks = 0;
  int n_fail   = 0;
  int ws [3]   = '{0, 2, 3};

  typedef struct {
    logic [31:0] ed;
    logic        ee;
  } exp_t;
  exp_t sb_q [$];

  typedef struct {
    int          inst;
    logic        r;
    logic        w;
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] ed;
    logic        ee;
  } vec_t;
  vec_t tv [17];

  data_mem_responder #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .read(rd[0]), .write(wr[0]), .addsel(addr[0]),
    .datain(din[0]), .dataout(dout[0]), .dataout_mem(dmem[0]), .ready(rdy[0]),
    .busy(bsy[0]), .err(er[0]));

  data_mem_responder #(.DATA_W(32), .ADDR_W(5), .DEPTH(16), .WAIT_STATES(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .read(rd[1]), .write(wr[1]), .addsel(addr[1]),
    .datain(din[1]), .dataout(dout[1]), .dataout_mem(dmem[1]), .ready(rdy[1]),
    .busy(bsy[1]), .err(er[1]));

  data_mem_responder #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .WAIT_STATES(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .read(rd[2]), .write(wr[2]), .addsel(addr[2]),
    .datain(din[2]), .dataout(dout[2]), .dataout_mem(dmem[2]), .ready(rdy[2]),
    .busy(bsy[2]), .err(er[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one request for a single cycle, then wait (bounded) for ready and
  // compare against the scoreboard entry pushed at drive time.
  task automatic run(input int k, input logic r, input logic w, input logic [4:0] a,
                     input logic [31:0] d, input logic [31:0] ed, input logic ee);
    int   waited;
    exp_t e;
    @(negedge clk);
    rd[k] = r; wr[k] = w; addr[k] = a; din[k] = d;
    sb_q.push_back('{ed, ee});
    @(negedge clk);
    rd[k] = 1'b0; wr[k] = 1'b0;
    waited = 0;
    while (!rdy[k] && waited < 20) begin
      chk("busy_wait", 32'(bsy[k]), 32'd1);
      @(negedge clk);
      waited++;
    end
    e = sb_q.pop_front();
    if (!rdy[k]) begin
      chk("ready_timeout", 32'(rdy[k]), 32'd1);
    end else begin
      chk("latency", waited, ws[k]);
      chk("dataout", dout[k], e.ed);
      chk("dataout_mem", 32'(dmem[k]), 32'(e.ed[4:0]));
      chk("err", 32'(er[k]), 32'(e.ee));
      chk("busy_resp", 32'(bsy[k]), 32'd1);
    end
    @(negedge clk);
    chk("ready_pulse_end", 32'(rdy[k]), 32'd0);
    chk("busy_idle", 32'(bsy[k]), 32'd0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; din[k] = '0;
    end

    // Instance 0: no wait states, full depth
    tv[0]  = '{0, 1'b1, 1'b0, 5'd7,  32'h0,        32'h0,        1'b0};
    tv[1]  = '{0, 1'b0, 1'b1, 5'd3,  32'hDEADBEEF, 32'h0,        1'b0};
    tv[2]  = '{0, 1'b1, 1'b0, 5'd3,  32'h0,        32'hDEADBEEF, 1'b0};
    tv[3]  = '{0, 1'b1, 1'b1, 5'd5,  32'h12345678, 32'hDEADBEEF, 1'b1};
    tv[4]  = '{0, 1'b1, 1'b0, 5'd5,  32'h0,        32'h12345678, 1'b0};
    tv[5]  = '{0, 1'b1, 1'b0, 5'd31, 32'h0,        32'h0,        1'b0};
    tv[6]  = '{0, 1'b0, 1'b1, 5'd31, 32'hA5A5A5A5, 32'h0,        1'b0};
    tv[7]  = '{0, 1'b1, 1'b0, 5'd31, 32'h0,        32'hA5A5A5A5, 1'b0};
    // Instance 1: two wait states, DEPTH=16
    tv[8]  = '{1, 1'b0, 1'b1, 5'd4,  32'h11112222, 32'h0,        1'b0};
    tv[9]  = '{1, 1'b0, 1'b1, 5'd20, 32'hFFFF0000, 32'h0,        1'b1};
    tv[10] = '{1, 1'b1, 1'b0, 5'd4,  32'h0,        32'h11112222, 1'b0};
    tv[11] = '{1, 1'b1, 1'b0, 5'd20, 32'h0,        32'h11112222, 1'b1};
    tv[12] = '{1, 1'b1, 1'b0, 5'd3,  32'h0,        32'h0,        1'b0};
    tv[13] = '{1, 1'b0, 1'b1, 5'd15, 32'h00000077, 32'h0,        1'b0};
    tv[14] = '{1, 1'b1, 1'b0, 5'd15, 32'h0,        32'h00000077, 1'b0};
    tv[15] = '{1, 1'b1, 1'b0, 5'd16, 32'h0,        32'h00000077, 1'b1};
    // Instance 2: three wait states
    tv[16] = '{2, 1'b1, 1'b0, 5'd9,  32'h0,        32'h0,        1'b0};

    // Reset state held
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_dataout", dout[k], 32'h0);
      chk("rst_ready", 32'(rdy[k]), 32'd0);
      chk("rst_busy", 32'(bsy[k]), 32'd0);
      chk("rst_err", 32'(er[k]), 32'd0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++)
      run(tv[i].inst, tv[i].r, tv[i].w, tv[i].a, tv[i].d, tv[i].ed, tv[i].ee);

    // Reset mid-access: write to addr 9 on the 3-wait-state instance
    @(negedge clk);
    wr[2] = 1'b1; addr[2] = 5'd9; din[2] = 32'h55AA55AA;
    @(negedge clk);
    wr[2] = 1'b0;
    chk("midrst_busy_before", 32'(bsy[2]), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(bsy[2]), 32'd0);
    chk("midrst_ready", 32'(rdy[2]), 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("midrst_no_ready", 32'(rdy[2]), 32'd0);
      if (c == 2) rst_n = 1'b1;
    end
    run(2, 1'b1, 1'b0, 5'd9, 32'h0, 32'h0, 1'b0);
    // Memory was re-cleared on the other instances too
    run(0, 1'b1, 1'b0, 5'd3, 32'h0, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
